// File: rtl/perf_counter_bank_pkg.sv
// perf_counter_bank_pkg: shared opcodes, RUN/HALTED state encoding and counter mode constants
package perf_counter_bank_pkg;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_STOP = 4'b0001;
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;
endpackage

// File: rtl/perf_counter_channel.sv
// perf_counter_channel: one event counter with wrap/saturate, sticky overflow and snapshot shadow
//   i_clock, i_reset (sync, active-low), i_inc_en (count this edge), i_clear (zero count+ovf),
//   i_snap (capture pre-edge count), o_shadow (captured count), o_ovf (sticky overflow)
module perf_counter_channel
  import perf_counter_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = MODE_WRAP
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc_en,
  input  logic             i_clear,
  input  logic             i_snap,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_ovf
);
  logic [WIDTH-1:0] r_count;
  logic             w_at_max;
  logic [WIDTH-1:0] w_count_inc;
  assign w_at_max    = &r_count;
  assign w_count_inc = (w_at_max && SATURATE == MODE_SAT) ? r_count : r_count + WIDTH'(1);
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_count  <= '0;
      o_shadow <= '0;
      o_ovf    <= 1'b0;
    end else begin
      // snapshot reads the pre-edge count, so snap alongside clear keeps the uncleared value
      if (i_snap) o_shadow <= r_count;
      if (i_clear) begin
        r_count <= '0;
        o_ovf   <= 1'b0;
      end else if (i_inc_en) begin
        r_count <= w_count_inc;
        if (w_at_max) o_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters gated by a RUN/HALTED FSM with shadow readback
//   i_clock, i_reset (sync, active-low), i_instr (decode opcode), i_events (per-channel strobes),
//   i_clear, i_start (re-arm from HALTED), i_snap, i_rd_sel -> o_rd_data (shadow mux),
//   o_ovf (sticky per-channel overflow), o_running (state is RUN)
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter int         NUM_CH   = 4,
  parameter int         SELW     = 2,
  parameter logic [3:0] STOP_OP  = OP_STOP,
  parameter bit         SATURATE = MODE_WRAP
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [3:0]        i_instr,
  input  logic [NUM_CH-1:0] i_events,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_snap,
  input  logic [SELW-1:0]   i_rd_sel,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic [NUM_CH-1:0] o_ovf,
  output logic              o_running
);
  state_t           r_state;
  state_t           w_state_next;
  logic             w_stop;
  logic             w_count_en;
  logic [WIDTH-1:0] w_shadow [2**SELW];
  assign w_stop = i_instr == STOP_OP;
  always_comb begin
    w_state_next = w_stop ? ST_HALTED : (i_start ? ST_RUN : r_state);
    w_count_en   = r_state == ST_RUN && !w_stop && !i_clear;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= ST_RUN;
    else r_state <= w_state_next;
  end
  assign o_running = r_state == ST_RUN;
  // unused select codes read as zero-filled slots so the mux needs no range check
  for (genvar g = 0; g < 2**SELW; g++) begin : g_ch
    if (g < NUM_CH) begin : g_live
      perf_counter_channel #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_ch (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc_en(w_count_en && i_events[g]),
        .i_clear (i_clear),
        .i_snap  (i_snap),
        .o_shadow(w_shadow[g]),
        .o_ovf   (o_ovf[g])
      );
    end else begin : g_pad
      assign w_shadow[g] = '0;
    end
  end
  assign o_rd_data = w_shadow[i_rd_sel];
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed plan plus random stimulus on three configurations against a reference model
module tb_perf_counter_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, clr, start, snap;
  logic [3:0]  instr, ev;
  logic [1:0]  sel;
  logic [15:0] rd_a;
  logic [3:0]  rd_w, rd_s, ovf_a;
  logic [2:0]  ovf_w, ovf_s;
  logic        run_a, run_w, run_s;
  perf_counter_bank #(.WIDTH(16), .NUM_CH(4), .SELW(2), .STOP_OP(4'b0001), .SATURATE(1'b0)) u_a (
    .i_clock(clk), .i_reset(rst_n), .i_instr(instr), .i_events(ev), .i_clear(clr), .i_start(start),
    .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_a), .o_ovf(ovf_a), .o_running(run_a));
  perf_counter_bank #(.WIDTH(4), .NUM_CH(3), .SELW(2), .STOP_OP(4'b0001), .SATURATE(1'b0)) u_w (
    .i_clock(clk), .i_reset(rst_n), .i_instr(instr), .i_events(ev[2:0]), .i_clear(clr), .i_start(start),
    .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_w), .o_ovf(ovf_w), .o_running(run_w));
  perf_counter_bank #(.WIDTH(4), .NUM_CH(3), .SELW(2), .STOP_OP(4'b0001), .SATURATE(1'b1)) u_s (
    .i_clock(clk), .i_reset(rst_n), .i_instr(instr), .i_events(ev[2:0]), .i_clear(clr), .i_start(start),
    .i_snap(snap), .i_rd_sel(sel), .o_rd_data(rd_s), .o_ovf(ovf_s), .o_running(run_s));
  int unsigned cnt [3][4];
  int unsigned sh  [3][4];
  bit          mov [3][4];
  bit          halt[3];
  int unsigned lim [3] = '{65535, 15, 15};
  int          nch [3] = '{4, 3, 3};
  bit          sat [3] = '{1'b0, 1'b0, 1'b1};
  int          n_chk = 0;
  int          n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        halt[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          cnt[k][c] = 0;
          sh[k][c]  = 0;
          mov[k][c] = 1'b0;
        end
      end else begin
        if (snap) for (int c = 0; c < 4; c++) sh[k][c] = cnt[k][c];
        if (clr) begin
          for (int c = 0; c < 4; c++) begin
            cnt[k][c] = 0;
            mov[k][c] = 1'b0;
          end
        end else if (!halt[k] && instr != 4'b0001) begin
          for (int c = 0; c < nch[k]; c++) if (ev[c]) begin
            if (cnt[k][c] == lim[k]) begin
              mov[k][c] = 1'b1;
              cnt[k][c] = sat[k] ? lim[k] : 0;
            end else cnt[k][c]++;
          end
        end
        if (instr == 4'b0001) halt[k] = 1'b1;
        else if (start) halt[k] = 1'b0;
      end
    end
  endtask
  task automatic compare();
    logic [31:0] e_rd[3];
    logic [3:0]  e_ov[3];
    for (int k = 0; k < 3; k++) begin
      e_rd[k] = (int'(sel) < nch[k]) ? sh[k][sel] : 0;
      e_ov[k] = '0;
      for (int c = 0; c < nch[k]; c++) e_ov[k][c] = mov[k][c];
    end
    chk("rd_a", rd_a, e_rd[0]);
    chk("rd_w", rd_w, e_rd[1]);
    chk("rd_s", rd_s, e_rd[2]);
    chk("ovf_a", ovf_a, e_ov[0]);
    chk("ovf_w", ovf_w, e_ov[1]);
    chk("ovf_s", ovf_s, e_ov[2]);
    chk("run_a", run_a, !halt[0]);
    chk("run_w", run_w, !halt[1]);
    chk("run_s", run_s, !halt[2]);
  endtask
  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  endtask
  initial begin
    rst_n = 1'b0; instr = 4'b0; ev = 4'b0; clr = 1'b0; start = 1'b0; snap = 1'b0; sel = 2'd0;
    run(2);
    chk("rst_rd", rd_a, 0);
    chk("rst_run", run_a, 1);
    chk("rst_ovf", ovf_a, 0);
    rst_n = 1'b1; ev = 4'b0001; run(10);
    ev = 4'b0; snap = 1'b1; run(1); snap = 1'b0;
    chk("cnt10", rd_a, 10);
    chk("cnt10_run", run_a, 1);
    clr = 1'b1; run(1); clr = 1'b0;
    ev = 4'b0001; run(5);
    ev = 4'b1111; instr = 4'b0001; run(1); instr = 4'b0;
    ev = 4'b0001; run(20);
    snap = 1'b1; run(1); snap = 1'b0;
    chk("halt_cnt", rd_a, 5);
    chk("halt_run", run_a, 0);
    start = 1'b1; run(1); start = 1'b0;
    chk("start_run", run_a, 1);
    run(1);
    ev = 4'b0; snap = 1'b1; run(1); snap = 1'b0;
    chk("resume_cnt", rd_a, 6);
    clr = 1'b1; run(1); clr = 1'b0;
    ev = 4'b0010; run(17);
    ev = 4'b0; sel = 2'd1; snap = 1'b1; run(1); snap = 1'b0;
    chk("wrap_cnt", rd_w, 1);
    chk("wrap_ovf", ovf_w[1], 1);
    chk("sat_cnt", rd_s, 15);
    chk("sat_ovf", ovf_s[1], 1);
    chk("wide_cnt", rd_a, 17);
    chk("wide_ovf", ovf_a[1], 0);
    clr = 1'b1; run(1); clr = 1'b0;
    ev = 4'b0100; run(7);
    clr = 1'b1; snap = 1'b1; sel = 2'd2; run(1); clr = 1'b0; snap = 1'b0; ev = 4'b0;
    chk("clrsnap_sh", rd_a, 7);
    chk("clrsnap_ovf", ovf_a, 0);
    snap = 1'b1; run(1); snap = 1'b0;
    chk("clr_cnt", rd_a, 0);
    ev = 4'b1111; run(1);
    instr = 4'b0001; run(1);
    chk("stop_run", run_a, 0);
    start = 1'b1; run(1);
    chk("startstop_run", run_a, 0);
    start = 1'b0; instr = 4'b0; run(3);
    chk("still_halt", run_a, 0);
    snap = 1'b1; sel = 2'd0; run(1); snap = 1'b0;
    chk("halt_hold", rd_a, 1);
    ev = 4'b0; start = 1'b1; run(1); start = 1'b0;
    clr = 1'b1; run(1); clr = 1'b0;
    ev = 4'b0100; run(25);
    ev = 4'b0; snap = 1'b1; sel = 2'd2; run(1); snap = 1'b0;
    chk("mid_w", rd_w, 9);
    chk("mid_ovf", ovf_w[2], 1);
    chk("mid_s", rd_s, 15);
    sel = 2'd3; #1;
    chk("sel3_w", rd_w, 0);
    rst_n = 1'b0; ev = 4'b0100; run(1); rst_n = 1'b1; ev = 4'b0;
    sel = 2'd2; #1;
    chk("post_rst_rd", rd_w, 0);
    chk("post_rst_ovf", ovf_w, 0);
    chk("post_rst_run", run_w, 1);
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      instr = ($urandom_range(0, 19) == 0) ? 4'b0001 : 4'($urandom_range(2, 15));
      ev    = 4'($urandom);
      clr   = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 7) == 0);
      snap  = ($urandom_range(0, 3) == 0);
      sel   = 2'($urandom);
      run(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
